// File: rtl/adc_arbiter_pkg.sv
// rtl/adc_arbiter_pkg.sv - shared state encoding, timeout defaults and timer helper for adc_arbiter
package adc_arbiter_pkg;

  localparam int TIMER_W = 10;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LAUNCH = 3'd1;
  localparam logic [2:0] ST_BUSY   = 3'd2;
  localparam logic [2:0] ST_DONE   = 3'd3;
  localparam logic [2:0] ST_GAP    = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_LAUNCH = ST_LAUNCH,
    S_BUSY   = ST_BUSY,
    S_DONE   = ST_DONE,
    S_GAP    = ST_GAP
  } state_t;

  localparam int DEF_GAP_CYC   = 4;
  localparam int DEF_LAUNCH_TO = 8;
  localparam int DEF_FRAME_TO  = 1023;

  // Saturating increment: the timer parks at all-ones instead of wrapping to 0.
  function automatic logic [TIMER_W-1:0] timer_inc(input logic [TIMER_W-1:0] t);
    return (&t) ? t : t + 1'b1;
  endfunction

endpackage

// File: rtl/adc_arbiter_rr_arb2.sv
// rtl/adc_arbiter_rr_arb2.sv - two-way round-robin grant with last-served pointer
module rr_arb2 (
  input  logic clk,
  input  logic n_rst,
  input  logic req0,
  input  logic req1,
  input  logic update,
  input  logic served,
  output logic gnt_valid,
  output logic gnt_idx
);

  // prio = 0 favours req0 on a tie, prio = 1 favours req1
  logic prio;

  // After serving a requester, the other one wins the next tie
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      prio <= 1'b0;
    end else if (update) begin
      prio <= ~served;
    end
  end

  // A lone request wins outright; a tie goes to the favoured side
  always_comb begin
    gnt_valid = req0 | req1;
    gnt_idx   = (req0 && req1) ? prio : req1;
  end

endmodule

// File: rtl/adc_arbiter.sv
// rtl/adc_arbiter.sv - shares one SPI ADC master between two level-request clients
module adc_arbiter
  import adc_arbiter_pkg::*;
#(
  parameter int GAP_CYC   = DEF_GAP_CYC,
  parameter int LAUNCH_TO = DEF_LAUNCH_TO,
  parameter int FRAME_TO  = DEF_FRAME_TO
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       req0,
  input  logic       req1,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] rdata,
  output logic       rerr,
  output logic       busy,
  output logic       spi_start,
  input  logic       spi_cs_n,
  input  logic [7:0] spi_adc_data
);

  // Timer reads 0 in the first cycle of a state, so "last" values make a
  // state last exactly N cycles before its timeout/exit fires.
  localparam logic [TIMER_W-1:0] LAUNCH_LAST = TIMER_W'(LAUNCH_TO - 1);
  localparam logic [TIMER_W-1:0] FRAME_LAST  = TIMER_W'(FRAME_TO - 1);
  localparam logic [TIMER_W-1:0] GAP_LAST    = TIMER_W'(GAP_CYC - 1);

  state_t             state;
  logic [TIMER_W-1:0] timer;
  logic               grant;
  logic               cs_n_q;
  logic               gnt_valid;
  logic               gnt_idx;

  rr_arb2 u_rr_arb2 (
    .clk       (clk),
    .n_rst     (n_rst),
    .req0      (req0),
    .req1      (req1),
    .update    (state == S_DONE),
    .served    (grant),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Previous chip-select level, used to spot the end-of-frame rising edge
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cs_n_q <= 1'b1;
    end else begin
      cs_n_q <= spi_cs_n;
    end
  end

  // Frame sequencer with registered outputs; every state change clears the timer
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= S_IDLE;
      timer     <= '0;
      grant     <= 1'b0;
      spi_start <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata     <= 8'h00;
      rerr      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      timer     <= timer_inc(timer);
      spi_start <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      case (state)
        S_IDLE: begin
          // Hold off while the master still drives a frame
          if (gnt_valid && spi_cs_n) begin
            grant     <= gnt_idx;
            state     <= S_LAUNCH;
            timer     <= '0;
            spi_start <= 1'b1;
            busy      <= 1'b1;
          end
        end
        S_LAUNCH: begin
          if (!spi_cs_n) begin
            state <= S_BUSY;
            timer <= '0;
          end else if (timer == LAUNCH_LAST) begin
            state <= S_DONE;
            timer <= '0;
            rdata <= 8'h00;
            rerr  <= 1'b1;
            ack0  <= ~grant;
            ack1  <= grant;
          end
        end
        S_BUSY: begin
          if (spi_cs_n && !cs_n_q) begin
            state <= S_DONE;
            timer <= '0;
            rdata <= spi_adc_data;
            rerr  <= 1'b0;
            ack0  <= ~grant;
            ack1  <= grant;
          end else if (timer == FRAME_LAST) begin
            state <= S_DONE;
            timer <= '0;
            rdata <= 8'h00;
            rerr  <= 1'b1;
            ack0  <= ~grant;
            ack1  <= grant;
          end
        end
        S_DONE: begin
          state <= S_GAP;
          timer <= '0;
          busy  <= 1'b0;
        end
        S_GAP: begin
          if (timer == GAP_LAST) begin
            state <= S_IDLE;
            timer <= '0;
          end
        end
        default: begin
          state <= S_IDLE;
          timer <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_arbiter.sv
// tb/tb_adc_arbiter.sv - directed self-checking bench for adc_arbiter
module tb_adc_arbiter;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       req0 = 1'b0;
  logic       req1 = 1'b0;
  logic       ack0;
  logic       ack1;
  logic [7:0] rdata;
  logic       rerr;
  logic       busy;
  logic       spi_start;
  logic       spi_cs_n;
  logic [7:0] spi_adc_data;

  int tests = 0;
  int fails = 0;

  // SPI master model controls
  bit         m_never = 1'b0;
  bit         m_hold  = 1'b0;
  bit         m_abort = 1'b0;
  int         m_len   = 10;
  logic [7:0] m_q[$];

  // Monitor results
  int         cyc = 0;
  int         n_start = 0;
  int         n_double = 0;
  int         n_ack0 = 0;
  int         n_ack1 = 0;
  int         n_both = 0;
  int         start_cyc = 0;
  int         ack_cyc = 0;
  int         rise_cyc = 0;
  int         last_hi_run = 0;
  logic [7:0] last_dat = 8'h00;
  logic       last_err = 1'b0;
  int         ack_who[$];
  logic [7:0] ack_dat[$];

  adc_arbiter dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .req0         (req0),
    .req1         (req1),
    .ack0         (ack0),
    .ack1         (ack1),
    .rdata        (rdata),
    .rerr         (rerr),
    .busy         (busy),
    .spi_start    (spi_start),
    .spi_cs_n     (spi_cs_n),
    .spi_adc_data (spi_adc_data)
  );

  // 100 MHz clock, posedges at 5, 15, 25 ...
  always #5 clk = ~clk;

  // Monitor plus SPI master model, both evaluated on the falling edge
  initial begin : env
    int         cnt;
    bit         active;
    bit         prev_start;
    bit         prev_cs;
    int         hi_run;
    logic [7:0] dat;
    cnt = 0; active = 0; prev_start = 0; prev_cs = 1; hi_run = 0; dat = 8'h00;
    spi_cs_n = 1'b1;
    spi_adc_data = 8'h00;
    forever begin
      @(negedge clk);
      cyc++;
      if (spi_start) begin
        n_start++;
        start_cyc = cyc;
        if (prev_start) n_double++;
      end
      prev_start = spi_start;
      if (ack0 && ack1) n_both++;
      if (ack0 || ack1) begin
        if (ack0) n_ack0++; else n_ack1++;
        ack_cyc = cyc;
        ack_who.push_back(ack1 ? 1 : 0);
        ack_dat.push_back(rdata);
        last_dat = rdata;
        last_err = rerr;
      end
      if (spi_cs_n) begin
        hi_run++;
      end else begin
        if (prev_cs) last_hi_run = hi_run;
        hi_run = 0;
      end
      prev_cs = spi_cs_n;
      if (!n_rst || m_abort) begin
        spi_cs_n = 1'b1;
        active = 0;
      end else if (spi_start && !m_never) begin
        active = 1;
        cnt = 0;
        spi_cs_n = 1'b0;
        spi_adc_data = 8'h00;
        if (m_q.size() > 0) dat = m_q.pop_front();
        else dat = 8'h5A;
      end else if (active && !m_hold) begin
        cnt++;
        if (cnt >= m_len) begin
          spi_cs_n = 1'b1;
          spi_adc_data = dat;
          rise_cyc = cyc;
          active = 0;
        end
      end
    end
  end

  // Hard stop in case something upstream never returns
  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no summary, want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic apply_reset();
    @(posedge clk); #1;
    n_rst = 1'b0;
    m_q.delete();
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
  endtask

  task automatic wait_acks(input int target, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (n_ack0 + n_ack1 >= target) begin
        ok = 1;
        break;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    #3;
    tests++; if (ack0 !== 1'b0) begin fails++; $display("FAIL rst_ack0: got %b want 0", ack0); end
    tests++; if (ack1 !== 1'b0) begin fails++; $display("FAIL rst_ack1: got %b want 0", ack1); end
    tests++; if (rdata !== 8'h00) begin fails++; $display("FAIL rst_rdata: got %h want 00", rdata); end
    tests++; if (rerr !== 1'b0) begin fails++; $display("FAIL rst_rerr: got %b want 0", rerr); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", busy); end
    tests++; if (spi_start !== 1'b0) begin fails++; $display("FAIL rst_start: got %b want 0", spi_start); end
    req0 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (spi_start !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL rst_held: got start=%b busy=%b want 0 0", spi_start, busy); end
    req0 = 1'b0;
    #1 n_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_single_req0();
    int s0, a0, a1;
    bit ok;
    s0 = n_start; a0 = n_ack0; a1 = n_ack1;
    m_len = 375;
    m_q.push_back(8'hA5);
    req0 = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy: got %b want 1", busy); end
    wait_acks(a0 + a1 + 1, 1000, ok);
    req0 = 1'b0;
    tests++; if (!ok) begin fails++; $display("FAIL single_wait: got timeout want ack"); end
    tests++; if (n_start - s0 !== 1) begin fails++; $display("FAIL single_starts: got %0d want 1", n_start - s0); end
    tests++; if (n_ack0 - a0 !== 1) begin fails++; $display("FAIL single_ack0: got %0d want 1", n_ack0 - a0); end
    tests++; if (n_ack1 - a1 !== 0) begin fails++; $display("FAIL single_ack1: got %0d want 0", n_ack1 - a1); end
    tests++; if (last_dat !== 8'hA5) begin fails++; $display("FAIL single_rdata: got %h want a5", last_dat); end
    tests++; if (last_err !== 1'b0) begin fails++; $display("FAIL single_rerr: got %b want 0", last_err); end
    tests++; if (ack_cyc - start_cyc !== 376) begin fails++; $display("FAIL single_frame_len: got %0d want 376", ack_cyc - start_cyc); end
    tests++; if (ack_cyc - rise_cyc !== 1) begin fails++; $display("FAIL single_ack_latency: got %0d want 1", ack_cyc - rise_cyc); end
    repeat (15) @(posedge clk);
    #1;
    tests++; if (rdata !== 8'hA5) begin fails++; $display("FAIL single_rdata_hold: got %h want a5", rdata); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_idle_busy: got %b want 0", busy); end
    tests++; if (n_ack0 - a0 !== 1) begin fails++; $display("FAIL single_ack_once: got %0d want 1", n_ack0 - a0); end
  endtask

  task automatic test_rr_after_reset();
    int qb, a;
    bit ok;
    apply_reset();
    m_len = 20;
    m_q.push_back(8'h11);
    m_q.push_back(8'h22);
    qb = ack_who.size();
    a = n_ack0 + n_ack1;
    req0 = 1'b1; req1 = 1'b1;
    wait_acks(a + 2, 300, ok);
    req0 = 1'b0; req1 = 1'b0;
    tests++; if (!ok) begin fails++; $display("FAIL rr_wait: got timeout want 2 acks"); end
    if (ok) begin
      tests++; if (ack_who[qb] !== 0) begin fails++; $display("FAIL rr_first_who: got %0d want 0", ack_who[qb]); end
      tests++; if (ack_dat[qb] !== 8'h11) begin fails++; $display("FAIL rr_first_data: got %h want 11", ack_dat[qb]); end
      tests++; if (ack_who[qb+1] !== 1) begin fails++; $display("FAIL rr_second_who: got %0d want 1", ack_who[qb+1]); end
      tests++; if (ack_dat[qb+1] !== 8'h22) begin fails++; $display("FAIL rr_second_data: got %h want 22", ack_dat[qb+1]); end
    end
    tests++; if (last_hi_run < 4) begin fails++; $display("FAIL rr_gap: got %0d cs_n high cycles want >=4", last_hi_run); end
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic test_launch_timeout();
    int s0, a;
    bit ok;
    s0 = n_start;
    a = n_ack0 + n_ack1;
    m_never = 1'b1;
    req0 = 1'b1;
    wait_acks(a + 1, 100, ok);
    req0 = 1'b0;
    m_never = 1'b0;
    tests++; if (!ok) begin fails++; $display("FAIL launch_wait: got timeout want ack"); end
    tests++; if (last_err !== 1'b1) begin fails++; $display("FAIL launch_rerr: got %b want 1", last_err); end
    tests++; if (last_dat !== 8'h00) begin fails++; $display("FAIL launch_rdata: got %h want 00", last_dat); end
    tests++; if (ack_cyc - start_cyc !== 8) begin fails++; $display("FAIL launch_len: got %0d want 8", ack_cyc - start_cyc); end
    tests++; if (n_start - s0 !== 1) begin fails++; $display("FAIL launch_starts: got %0d want 1", n_start - s0); end
    m_len = 12;
    m_q.push_back(8'h3C);
    a = n_ack0 + n_ack1;
    req1 = 1'b1;
    wait_acks(a + 1, 200, ok);
    req1 = 1'b0;
    tests++; if (!ok) begin fails++; $display("FAIL launch_next_wait: got timeout want ack"); end
    tests++; if (ack_who[$] !== 1) begin fails++; $display("FAIL launch_next_who: got %0d want 1", ack_who[$]); end
    tests++; if (last_dat !== 8'h3C || last_err !== 1'b0) begin fails++; $display("FAIL launch_next_data: got %h/%b want 3c/0", last_dat, last_err); end
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic test_frame_timeout();
    int s0, a, qb;
    bit ok;
    m_len = 20;
    m_hold = 1'b1;
    a = n_ack0 + n_ack1;
    req0 = 1'b1;
    wait_acks(a + 1, 1200, ok);
    req0 = 1'b0;
    tests++; if (!ok) begin fails++; $display("FAIL frame_wait: got timeout want ack"); end
    tests++; if (last_err !== 1'b1 || last_dat !== 8'h00) begin fails++; $display("FAIL frame_err: got %h/%b want 00/1", last_dat, last_err); end
    tests++; if (ack_cyc - start_cyc !== 1024) begin fails++; $display("FAIL frame_len: got %0d want 1024", ack_cyc - start_cyc); end
    tests++; if (ack_who[$] !== 0) begin fails++; $display("FAIL frame_who: got %0d want 0", ack_who[$]); end
    s0 = n_start;
    req0 = 1'b1; req1 = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    tests++; if (n_start !== s0) begin fails++; $display("FAIL frame_cs_low_hold: got %0d starts want 0", n_start - s0); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL frame_cs_low_busy: got %b want 0", busy); end
    m_q.push_back(8'h77);
    m_q.push_back(8'h88);
    qb = ack_who.size();
    a = n_ack0 + n_ack1;
    m_abort = 1'b1;
    @(posedge clk);
    #1;
    m_abort = 1'b0;
    m_hold = 1'b0;
    wait_acks(a + 2, 300, ok);
    req0 = 1'b0; req1 = 1'b0;
    tests++; if (!ok) begin fails++; $display("FAIL frame_after_wait: got timeout want 2 acks"); end
    if (ok) begin
      tests++; if (ack_who[qb] !== 1 || ack_dat[qb] !== 8'h77) begin fails++; $display("FAIL frame_ptr_first: got %0d/%h want 1/77", ack_who[qb], ack_dat[qb]); end
      tests++; if (ack_who[qb+1] !== 0 || ack_dat[qb+1] !== 8'h88) begin fails++; $display("FAIL frame_ptr_second: got %0d/%h want 0/88", ack_who[qb+1], ack_dat[qb+1]); end
    end
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_busy();
    int s0, a0, a;
    bit ok;
    s0 = n_start;
    m_len = 200;
    m_q.push_back(8'h99);
    req0 = 1'b1;
    for (int i = 0; i < 50 && n_start == s0; i++) @(posedge clk);
    repeat (50) @(posedge clk);
    #1;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL midrst_pre_busy: got %b want 1", busy); end
    a0 = n_ack0;
    n_rst = 1'b0;
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b want 0", busy); end
    tests++; if (rdata !== 8'h00) begin fails++; $display("FAIL midrst_rdata: got %h want 00", rdata); end
    tests++; if (ack0 !== 1'b0 || ack1 !== 1'b0 || rerr !== 1'b0 || spi_start !== 1'b0) begin fails++; $display("FAIL midrst_outs: got ack0=%b ack1=%b rerr=%b start=%b want 0 0 0 0", ack0, ack1, rerr, spi_start); end
    req0 = 1'b0;
    repeat (3) @(posedge clk);
    #1 n_rst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    tests++; if (n_ack0 !== a0) begin fails++; $display("FAIL midrst_no_ack: got %0d acks want 0", n_ack0 - a0); end
    m_q.push_back(8'h42);
    a = n_ack0 + n_ack1;
    req0 = 1'b1;
    wait_acks(a + 1, 400, ok);
    req0 = 1'b0;
    tests++; if (!ok) begin fails++; $display("FAIL midrst_after_wait: got timeout want ack"); end
    tests++; if (last_dat !== 8'h42 || last_err !== 1'b0 || ack_who[$] !== 0) begin fails++; $display("FAIL midrst_after_data: got %h/%b/%0d want 42/0/0", last_dat, last_err, ack_who[$]); end
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int s0, d0, b0, qb, a;
    bit ok;
    apply_reset();
    m_len = 10;
    for (int i = 1; i <= 6; i++) m_q.push_back(8'(i));
    s0 = n_start; d0 = n_double; b0 = n_both;
    qb = ack_who.size();
    a = n_ack0 + n_ack1;
    req0 = 1'b1; req1 = 1'b1;
    wait_acks(a + 6, 600, ok);
    req0 = 1'b0; req1 = 1'b0;
    tests++; if (!ok) begin fails++; $display("FAIL b2b_wait: got timeout want 6 acks"); end
    if (ok) begin
      for (int i = 0; i < 6; i++) begin
        tests++; if (ack_who[qb+i] !== (i % 2) || ack_dat[qb+i] !== 8'(i + 1)) begin fails++; $display("FAIL b2b_frame%0d: got %0d/%h want %0d/%h", i, ack_who[qb+i], ack_dat[qb+i], i % 2, 8'(i + 1)); end
      end
    end
    repeat (20) @(posedge clk);
    #1;
    tests++; if (n_start - s0 !== 6) begin fails++; $display("FAIL b2b_starts: got %0d want 6", n_start - s0); end
    tests++; if (n_double !== d0) begin fails++; $display("FAIL b2b_double_start: got %0d want 0", n_double - d0); end
    tests++; if (n_both !== b0) begin fails++; $display("FAIL b2b_dual_ack: got %0d want 0", n_both - b0); end
  endtask

  initial begin
    test_reset();
    test_single_req0();
    test_rr_after_reset();
    test_launch_timeout();
    test_frame_timeout();
    test_reset_mid_busy();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
